// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding,
// memory-port mux select values and a wrapping counter helper.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        CORE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } arb_state_e;

    // Memory port source select
    localparam logic MUX_SEL_CORE   = 1'b0;
    localparam logic MUX_SEL_LOADER = 1'b1;

    localparam int STAT_W = 32;

    // 32-bit increment that wraps 0xFFFFFFFF back to zero
    function automatic logic [STAT_W-1:0] wrap_inc32(input logic [STAT_W-1:0] value);
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/data_mem_arb_stats.sv
// Statistics counters for the data memory arbiter: loader grant entries and
// core stall cycles. Both wrap silently. Only instantiated when the
// DATA_MEM_ARB_STATS_EN macro is defined.
module data_mem_arb_stats
    import data_mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              i_grant_entry,
    input  logic              i_stall,
    output logic [STAT_W-1:0] o_ld_grants,
    output logic [STAT_W-1:0] o_stall_cycles
);

    logic [STAT_W-1:0] r_ld_grants;
    logic [STAT_W-1:0] r_stall_cycles;

    // Count every entry into the loader grant state
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ld_grants <= 32'd0;
        end else if (i_grant_entry) begin
            r_ld_grants <= wrap_inc32(r_ld_grants);
        end else begin
            r_ld_grants <= r_ld_grants;
        end
    end

    // Count every cycle in which the core pipeline is frozen
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_stall_cycles <= 32'd0;
        end else if (i_stall) begin
            r_stall_cycles <= wrap_inc32(r_stall_cycles);
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign o_ld_grants    = r_ld_grants;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter between the core MEM stage and a loader/debug port.
// A loader request steals the memory port for one GRANT cycle followed by
// one ACK cycle, stalling the core for both. Back-to-back loader requests
// are limited to BURST_MAX grants before the core gets one cycle back.
// Optional statistics outputs are enabled with macro DATA_MEM_ARB_STATS_EN.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int BURST_MAX = 8
)(
    input  logic        clk,
    input  logic        rstN,
    input  logic [63:0] coreAddr,
    input  logic [63:0] coreWdata,
    input  logic        coreWe,
    input  logic [2:0]  coreFunct3,
    output logic [63:0] coreRdata,
    output logic        coreStall,
    input  logic        ldReq,
    input  logic [63:0] ldAddr,
    input  logic [63:0] ldWdata,
    input  logic        ldWe,
    input  logic [2:0]  ldFunct3,
    output logic        ldAck,
    output logic [63:0] ldRdata,
    output logic [63:0] memAddr,
    output logic [63:0] memWdata,
    output logic        memWe,
    output logic [2:0]  memFunct3,
    input  logic [63:0] memRdata
`ifdef DATA_MEM_ARB_STATS_EN
    ,
    output logic [31:0] statLdGrants,
    output logic [31:0] statStallCycles
`endif
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(BURST_MAX);

    arb_state_e       r_state;
    arb_state_e       w_next_state;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_next;
    logic [63:0]      r_ld_rdata;
    logic             w_mux_sel;

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= CORE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grant on request, always acknowledge, burst-limited re-grant
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CORE: begin
                if (ldReq) begin
                    w_next_state = GRANT;
                end else begin
                    w_next_state = CORE;
                end
            end
            GRANT: begin
                w_next_state = ACK;
            end
            ACK: begin
                if (ldReq && (r_burst_cnt < BURST_LIMIT)) begin
                    w_next_state = GRANT;
                end else begin
                    w_next_state = CORE;
                end
            end
            default: begin
                w_next_state = CORE;
            end
        endcase
    end

    // Burst count: restarts at one on the first grant out of CORE,
    // advances on each chained grant, clears while the core owns the port
    always_comb begin
        w_burst_cnt_next = r_burst_cnt;
        if (r_state == CORE) begin
            if (w_next_state == GRANT) begin
                w_burst_cnt_next = CNT_W'(1);
            end else begin
                w_burst_cnt_next = '0;
            end
        end else if ((r_state == ACK) && (w_next_state == GRANT)) begin
            w_burst_cnt_next = r_burst_cnt + CNT_W'(1);
        end else begin
            w_burst_cnt_next = r_burst_cnt;
        end
    end

    // Burst count register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= w_burst_cnt_next;
        end
    end

    // Capture memory read data for the loader at the end of the grant cycle
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_ld_rdata <= 64'd0;
        end else if (r_state == GRANT) begin
            r_ld_rdata <= memRdata;
        end else begin
            r_ld_rdata <= r_ld_rdata;
        end
    end

    // Memory port mux: core fields only while the core owns the port;
    // the write strobe is suppressed in ACK so stalled core stores never land
    always_comb begin
        w_mux_sel = MUX_SEL_CORE;
        memWe     = 1'b0;
        case (r_state)
            CORE: begin
                w_mux_sel = MUX_SEL_CORE;
                memWe     = coreWe;
            end
            GRANT: begin
                w_mux_sel = MUX_SEL_LOADER;
                memWe     = ldWe;
            end
            ACK: begin
                w_mux_sel = MUX_SEL_LOADER;
                memWe     = 1'b0;
            end
            default: begin
                w_mux_sel = MUX_SEL_CORE;
                memWe     = 1'b0;
            end
        endcase
    end

    assign memAddr   = (w_mux_sel == MUX_SEL_LOADER) ? ldAddr   : coreAddr;
    assign memWdata  = (w_mux_sel == MUX_SEL_LOADER) ? ldWdata  : coreWdata;
    assign memFunct3 = (w_mux_sel == MUX_SEL_LOADER) ? ldFunct3 : coreFunct3;

    assign coreRdata = memRdata;
    assign coreStall = (r_state != CORE);
    assign ldAck     = (r_state == ACK);
    assign ldRdata   = r_ld_rdata;

`ifdef DATA_MEM_ARB_STATS_EN
    logic w_grant_entry;
    assign w_grant_entry = (w_next_state == GRANT);

    data_mem_arb_stats u_stats (
        .clk            (clk),
        .rstN           (rstN),
        .i_grant_entry  (w_grant_entry),
        .i_stall        (coreStall),
        .o_ld_grants    (statLdGrants),
        .o_stall_cycles (statStallCycles)
    );
`endif

endmodule
